uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Serial-to-byte receiver for the UART upload path. It oversamples the UART RX pin with the system clock, recovers 8N1 frames, and holds each byte in a one-entry buffer. The buffer is exposed through the Empty/Unload_data handshake consumed by the UART-to-SRAM byte assembler. It also reports overrun and framing errors.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
- Clock  in  1  system clock, rising-edge.
- Resetn  in  1  reset; one clock, reset is synchronous and active-low.
- Enable  in  1  receiver enable.
  - 0 forces the FSM to idle, sets Empty=1 and clears Overrun.
- UART_RX_I  in  1  asynchronous serial line; idles high.
- Unload_data  in  1  consumer acknowledge; level-sensitive.
- RX_data  out  8  last accepted byte. Held until the next accepted byte.
- Empty  out  1  1 means no unread byte is buffered.
- Overrun  out  1  sticky; a completed byte was dropped because the buffer was full.
- Frame_error  out  4  saturating count of frames whose stop bit sampled low.

## Operation
- Input conditioning: 2-flop synchronizer on UART_RX_I, then a 1-flop delayed copy for falling-edge detection. Downstream logic uses only the synchronized line.
- FSM states: S_RX_IDLE, S_RX_START, S_RX_DATA, S_RX_STOP. 16-bit cycle counter, 3-bit bit index.
- S_RX_IDLE
  - Requires Enable=1.
  - A falling edge (previous sample 1, current 0) clears the counter and moves to S_RX_START.
  - A line held low, e.g. a break, never re-triggers.
- S_RX_START
  - At counter = CLKS_PER_BIT/2 - 1, sample the line.
  - Low: clear the counter and go to S_RX_DATA.
  - High: false start; return to S_RX_IDLE with no error recorded.
- S_RX_DATA
  - Every CLKS_PER_BIT cycles, sample one bit, LSB first, into a shift register.
  - After bit 7, go to S_RX_STOP.
- S_RX_STOP, after CLKS_PER_BIT cycles, samples the stop bit:
  - High: the byte is complete.
  - Low: Frame_error increments, saturating at 4'hF. The byte is discarded and the buffer is untouched.
  - Either way, return to S_RX_IDLE.
- Buffer, on a completed byte:
  - Empty=1: load RX_data, Empty<=0.
  - Empty=0 and Unload_data=0: drop the byte, Overrun<=1, RX_data unchanged.
- Unload_data=1 with Empty=0 sets Empty<=1 on the next edge.
- Simultaneous unload and completed byte in the same cycle: the new byte loads, Empty stays 0, no overrun.
- Unload_data=1 while Empty=1 has no effect.
- Enable falling mid-frame aborts the frame: idle, Empty=1, Overrun=0. Frame_error is retained.
- Frame_error clears only on reset.

## Timing
- Reset values: RX_data=8'h00, Empty=1, Overrun=0, Frame_error=4'h0, FSM in S_RX_IDLE, counter and shift register zeroed, synchronizer flops reset to 1.
- Edge-to-sample offset: detecting the synchronized falling edge adds 2 cycles after the pin edge.
- Stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the detected edge.
- Empty=0 and RX_data valid on the cycle after the stop-sample cycle (1-cycle latency).
- Consumer contract: hold Unload_data until Empty=1 is observed, then drop it. Empty returns to 0 no earlier than the next completed frame.
- Reset asserted mid-frame: all outputs return to reset values on the next edge.

## Configuration
- UART_RX_MAJORITY_VOTE_EN
  - Defined: every start, data and stop bit is decided by a 2-of-3 majority of synchronized samples at offsets mid-1, mid and mid+1. The decision and all downstream events (Empty fall, error updates) move 1 cycle later.
  - Undefined: single sample at the midpoint.

## Structure
- State enum UART_RX_state_type (S_RX_IDLE..S_RX_STOP) goes in the shared state header alongside the other FSM typedefs.
- One sub-module, uart_rx_sync: the 2-flop synchronizer plus edge detector. Outputs rx_sync and rx_fall, reset to idle-high.

## Test plan
- Defaults; send 0xA5 in 8N1 -> RX_data=8'hA5; Empty falls exactly 1 cycle after the stop sample; Overrun=0; Frame_error=0.
- Send 0x3C then 0x7E with Unload_data held 0 -> RX_data=8'h3C, Overrun=1. Then Unload -> Empty=1 on the next edge.
- Stop bit driven low on 0x55 -> Frame_error=1, Empty stays 1. Sixteen such frames -> Frame_error=4'hF.
- 100-cycle low glitch on the idle line -> no byte, no error, FSM back in idle. With UART_RX_MAJORITY_VOTE_EN: 1-cycle spikes inside data bits of 0x0F -> RX_data=8'h0F.
- Unload_data asserted in the same cycle a second byte 0x81 completes -> RX_data=8'h81, Empty=0, Overrun=0.
- Enable=0 and Resetn=0 each applied mid-frame -> idle, Empty=1, Overrun=0. Frame_error is kept on the Enable drop and zeroed on reset. The next 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and helpers for the UART receive path.
// UART_RX_MAJORITY_VOTE_EN is consumed by uart_rx_deserializer; this
// package only supplies the vote helper it needs.
package uart_rx_deserializer_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        S_RX_IDLE  = 2'd0,
        S_RX_START = 2'd1,
        S_RX_DATA  = 2'd2,
        S_RX_STOP  = 2'd3
    } UART_RX_state_type;

    localparam int CNT_W     = 16;
    localparam int BIT_IDX_W = 3;
    localparam int FE_W      = 4;

    // 2-of-3 majority of three line samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Increment that sticks at all-ones
    function automatic logic [FE_W-1:0] sat_inc(input logic [FE_W-1:0] v);
        return (v == {FE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus a delayed copy
// used to detect the high-to-low transition that starts a frame.
// All flops reset to the line's idle-high level so reset never looks
// like a start edge.
module uart_rx_sync (
    input  logic Clock,
    input  logic Resetn,
    input  logic UART_RX_I,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronize the pin and keep one older sample for edge detection
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= UART_RX_I;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rx_sync = sync;
    assign rx_fall = prev & ~sync;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver with a one-entry output buffer (Empty/Unload_data
// handshake), sticky overrun flag and saturating framing-error count.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN -- decide every bit by a
// 2-of-3 vote over mid-1/mid/mid+1, which shifts all decisions one cycle.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Enable,
    input  logic       UART_RX_I,
    input  logic       Unload_data,
    output logic [7:0] RX_data,
    output logic       Empty,
    output logic       Overrun,
    output logic [3:0] Frame_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif

    // Start is judged near mid-bit; after that every bit is a full period
    // later, so only the start point carries the vote delay.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT - 1 + VOTE_DLY);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_sync;
    logic rx_fall;
    logic bit_val;

    UART_RX_state_type      state;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [7:0]             shreg;
    logic                   byte_done;
    logic                   stop_bad;

    uart_rx_sync u_sync (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .UART_RX_I(UART_RX_I),
        .rx_sync  (rx_sync),
        .rx_fall  (rx_fall)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist;

    // Two older synchronized samples so the vote sees mid-1, mid, mid+1
    always_ff @(posedge Clock) begin
        if (!Resetn) hist <= 2'b11;
        else         hist <= {hist[0], rx_sync};
    end

    assign bit_val = maj3(rx_sync, hist[0], hist[1]);
`else
    assign bit_val = rx_sync;
`endif

    // Frame recovery FSM; byte_done / stop_bad are one-cycle result pulses
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= S_RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            stop_bad  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            stop_bad  <= 1'b0;
            if (!Enable) begin
                state   <= S_RX_IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    S_RX_IDLE: begin
                        // Edge-triggered, so a held-low (break) line cannot retrigger
                        if (rx_fall) begin
                            cnt   <= '0;
                            state <= S_RX_START;
                        end
                    end
                    S_RX_START: begin
                        if (cnt == START_LAST) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            // High at mid-start is a glitch: back to idle silently
                            state   <= bit_val ? S_RX_IDLE : S_RX_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RX_DATA: begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
                            // LSB arrives first and ends up in bit 0 after 8 shifts
                            shreg <= {bit_val, shreg[7:1]};
                            if (bit_idx == 3'd7) state <= S_RX_STOP;
                            else                 bit_idx <= bit_idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RX_STOP: begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
                            state <= S_RX_IDLE;
                            if (bit_val) byte_done <= 1'b1;
                            else         stop_bad  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_RX_IDLE;
                endcase
            end
        end
    end

    // One-entry buffer, overrun flag and error count driven by the FSM pulses
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            RX_data     <= 8'h00;
            Empty       <= 1'b1;
            Overrun     <= 1'b0;
            Frame_error <= 4'h0;
        end else begin
            if (stop_bad) Frame_error <= sat_inc(Frame_error);
            if (!Enable) begin
                Empty   <= 1'b1;
                Overrun <= 1'b0;
            end else if (byte_done) begin
                // An unload in the same cycle frees the slot for the new byte
                if (Empty || Unload_data) begin
                    RX_data <= shreg;
                    Empty   <= 1'b0;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (Unload_data && !Empty) begin
                Empty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer. Frames are generated
// bit-by-bit on the pin; expected outputs come from a frame-level model.
module tb_uart_rx_deserializer;

    localparam int CLK_FREQ = 20_400_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;   // 204
    localparam int HALF     = CPB / 2;           // 102, longer than the 100-cycle glitch
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif
    // Pin change -> two synchronizer flops -> edge seen on the 3rd edge.
    // Stop sample HALF+9*CPB after that, buffer updates one edge later.
    localparam int DONE_EDGE = 3 + HALF + 9 * CPB + VOTE + 1;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Enable = 1'b1;
    logic       UART_RX_I = 1'b1;
    logic       Unload_data = 1'b0;
    logic [7:0] RX_data;
    logic       Empty;
    logic       Overrun;
    logic [3:0] Frame_error;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    logic [7:0] m_data;
    logic       m_empty;
    logic       m_ovr;
    int         m_fe;

    uart_rx_deserializer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Enable     (Enable),
        .UART_RX_I  (UART_RX_I),
        .Unload_data(Unload_data),
        .RX_data    (RX_data),
        .Empty      (Empty),
        .Overrun    (Overrun),
        .Frame_error(Frame_error)
    );

    always #5 Clock = ~Clock;

    function automatic void model_reset();
        m_data = 8'h00; m_empty = 1'b1; m_ovr = 1'b0; m_fe = 0;
    endfunction

    function automatic void model_frame(input logic [7:0] d, input bit ok, input bit unload);
        if (!ok)                     m_fe = (m_fe == 15) ? 15 : m_fe + 1;
        else if (m_empty || unload) begin m_data = d; m_empty = 1'b0; end
        else                         m_ovr = 1'b1;
    endfunction

    // Drive one 8N1 frame slot by slot. unload_edge pulses Unload_data so it
    // is sampled at that edge; abort_edge stops the frame with Enable=0 or
    // Resetn=0. fall_edge reports the edge at which Empty went 1->0.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int unload_edge,
                              input int abort_edge, input bit abort_reset, input bit spikes,
                              output int fall_edge);
        logic prev_empty;
        logic b;
        fall_edge = -1;
        prev_empty = Empty;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k == abort_edge) begin
                UART_RX_I = 1'b1;
                if (abort_reset) begin
                    Resetn = 1'b0; @(posedge Clock); #1; Resetn = 1'b1;
                end else begin
                    Enable = 1'b0; repeat (3) @(posedge Clock); #1; Enable = 1'b1;
                end
                break;
            end
            if (k < CPB)          b = 1'b0;
            else if (k < 9 * CPB) b = d[k / CPB - 1];
            else                  b = stop_ok;
            if (spikes && k >= CPB && k < 9 * CPB && (k % CPB) == HALF) b = ~b;
            UART_RX_I = b;
            Unload_data = (k == unload_edge - 1);
            @(posedge Clock); #1;
            if (fall_edge < 0 && prev_empty === 1'b1 && Empty === 1'b0) fall_edge = k + 1;
            prev_empty = Empty;
        end
        Unload_data = 1'b0;
        UART_RX_I = 1'b1;
        repeat (4) @(posedge Clock);
        #1;
    endtask

    // Consumer handshake: hold Unload_data until Empty=1 is seen
    task automatic do_unload();
        int n = 0;
        Unload_data = 1'b1;
        while (Empty !== 1'b1 && n < 8) begin
            @(posedge Clock); #1; n++;
        end
        Unload_data = 1'b0;
        m_empty = 1'b1;
        n_total++;
        if (n !== 1) $display("FAIL unload_latency: took %0d edges, want 1", n);
        else n_pass++;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Enable = 1'b1; UART_RX_I = 1'b1; Unload_data = 1'b0;
        repeat (3) @(posedge Clock);
        #1; Resetn = 1'b1;
        model_reset();
        n_total++; if (RX_data !== 8'h00) $display("FAIL reset_data: %h want 00", RX_data); else n_pass++;
        n_total++; if (Empty !== 1'b1) $display("FAIL reset_empty: %b want 1", Empty); else n_pass++;
        n_total++; if (Overrun !== 1'b0) $display("FAIL reset_ovr: %b want 0", Overrun); else n_pass++;
        n_total++; if (Frame_error !== 4'h0) $display("FAIL reset_fe: %h want 0", Frame_error); else n_pass++;
        repeat (5) @(posedge Clock);
        #1;
    endtask

    task automatic test_single();
        int fe;
        send_frame(8'hA5, 1'b1, -1, -1, 1'b0, 1'b0, fe);
        model_frame(8'hA5, 1'b1, 1'b0);
        n_total++; if (fe !== DONE_EDGE) $display("FAIL single_timing: empty fell at edge %0d want %0d", fe, DONE_EDGE); else n_pass++;
        n_total++; if (RX_data !== m_data) $display("FAIL single_data: %h want %h", RX_data, m_data); else n_pass++;
        n_total++; if (Empty !== m_empty) $display("FAIL single_empty: %b want %b", Empty, m_empty); else n_pass++;
        n_total++; if (Overrun !== m_ovr || Frame_error !== 4'(m_fe))
            $display("FAIL single_err: ovr=%b fe=%h want %b %h", Overrun, Frame_error, m_ovr, 4'(m_fe)); else n_pass++;
        do_unload();
    endtask

    task automatic test_overrun();
        int fe;
        send_frame(8'h3C, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(8'h7E, 1'b1, 1'b0);
        n_total++; if (RX_data !== m_data) $display("FAIL ovr_data: %h want %h", RX_data, m_data); else n_pass++;
        n_total++; if (Overrun !== m_ovr) $display("FAIL ovr_flag: %b want %b", Overrun, m_ovr); else n_pass++;
        n_total++; if (Empty !== m_empty) $display("FAIL ovr_empty: %b want %b", Empty, m_empty); else n_pass++;
        do_unload();
        n_total++; if (Overrun !== m_ovr) $display("FAIL ovr_sticky: %b want %b", Overrun, m_ovr); else n_pass++;
    endtask

    task automatic test_frame_error();
        int fe;
        send_frame(8'h55, 1'b0, -1, -1, 1'b0, 1'b0, fe); model_frame(8'h55, 1'b0, 1'b0);
        n_total++; if (Frame_error !== 4'(m_fe)) $display("FAIL fe_one: %h want %h", Frame_error, 4'(m_fe)); else n_pass++;
        n_total++; if (Empty !== m_empty || RX_data !== m_data)
            $display("FAIL fe_buffer: empty=%b data=%h want %b %h", Empty, RX_data, m_empty, m_data); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h55, 1'b0, -1, -1, 1'b0, 1'b0, fe); model_frame(8'h55, 1'b0, 1'b0);
        end
        n_total++; if (Frame_error !== 4'(m_fe)) $display("FAIL fe_saturate: %h want %h", Frame_error, 4'(m_fe)); else n_pass++;
    endtask

    task automatic test_glitch();
        int fe;
        logic [7:0] d;
        UART_RX_I = 1'b0;
        repeat (100) @(posedge Clock);
        #1; UART_RX_I = 1'b1;
        repeat (3 * CPB) @(posedge Clock);
        #1;
        n_total++; if (Empty !== m_empty || RX_data !== m_data || Frame_error !== 4'(m_fe))
            $display("FAIL glitch: empty=%b data=%h fe=%h want %b %h %h", Empty, RX_data, Frame_error, m_empty, m_data, 4'(m_fe));
        else n_pass++;
        d = 8'($urandom);
        send_frame(d, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(d, 1'b1, 1'b0);
        n_total++; if (RX_data !== m_data || Empty !== m_empty)
            $display("FAIL glitch_next: data=%h empty=%b want %h %b", RX_data, Empty, m_data, m_empty); else n_pass++;
        do_unload();
`ifdef UART_RX_MAJORITY_VOTE_EN
        send_frame(8'h0F, 1'b1, -1, -1, 1'b0, 1'b1, fe); model_frame(8'h0F, 1'b1, 1'b0);
        n_total++; if (RX_data !== m_data) $display("FAIL vote_spikes: %h want %h", RX_data, m_data); else n_pass++;
        do_unload();
`endif
    endtask

    task automatic test_back_to_back();
        int fe;
        logic [7:0] d;
        // Enable pulse in idle clears the sticky overrun
        Enable = 1'b0; @(posedge Clock); #1; Enable = 1'b1;
        m_empty = 1'b1; m_ovr = 1'b0;
        n_total++; if (Overrun !== m_ovr || Empty !== m_empty)
            $display("FAIL enable_clear: ovr=%b empty=%b want %b %b", Overrun, Empty, m_ovr, m_empty); else n_pass++;
        d = 8'($urandom);
        send_frame(d, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(d, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, DONE_EDGE, -1, 1'b0, 1'b0, fe); model_frame(8'h81, 1'b1, 1'b1);
        n_total++; if (RX_data !== m_data || Empty !== m_empty || Overrun !== m_ovr)
            $display("FAIL collide: data=%h empty=%b ovr=%b want %h %b %b", RX_data, Empty, Overrun, m_data, m_empty, m_ovr);
        else n_pass++;
    endtask

    task automatic test_abort();
        int fe;
        // Buffer full and overrun set before each abort
        send_frame(8'h11, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, -1, 4 * CPB, 1'b0, 1'b0, fe);
        m_empty = 1'b1; m_ovr = 1'b0;
        n_total++; if (Empty !== m_empty || Overrun !== m_ovr || Frame_error !== 4'(m_fe))
            $display("FAIL enable_abort: empty=%b ovr=%b fe=%h want %b %b %h", Empty, Overrun, Frame_error, m_empty, m_ovr, 4'(m_fe));
        else n_pass++;
        send_frame(8'h22, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, -1, 5 * CPB, 1'b1, 1'b0, fe);
        model_reset();
        n_total++; if (RX_data !== m_data || Empty !== m_empty || Overrun !== m_ovr || Frame_error !== 4'(m_fe))
            $display("FAIL reset_abort: data=%h empty=%b ovr=%b fe=%h want %h %b %b %h",
                     RX_data, Empty, Overrun, Frame_error, m_data, m_empty, m_ovr, 4'(m_fe));
        else n_pass++;
        send_frame(8'hC3, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(8'hC3, 1'b1, 1'b0);
        n_total++; if (RX_data !== m_data || Empty !== m_empty)
            $display("FAIL after_reset: data=%h empty=%b want %h %b", RX_data, Empty, m_data, m_empty); else n_pass++;
    endtask

    task automatic test_random();
        int fe;
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 1) == 1 && !m_empty) do_unload();
            d = 8'($urandom);
            send_frame(d, 1'b1, -1, -1, 1'b0, 1'b0, fe); model_frame(d, 1'b1, 1'b0);
            n_total++; if (RX_data !== m_data || Empty !== m_empty || Overrun !== m_ovr)
                $display("FAIL random_%0d: data=%h empty=%b ovr=%b want %h %b %b",
                         i, RX_data, Empty, Overrun, m_data, m_empty, m_ovr);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
